// File: rtl/sr_feeder00.sv
// Delay-line feeder: pairs each second-half beat with the stored first-half beat (1-cycle latency), then drains butterfly results.
// din_ready drops during WAIT/DRAIN; optional sticky overflow flag via SR_FEEDER_OVF_CHK_EN.
module sr_feeder00 #(
    parameter int DATA_W    = 9,
    parameter int SUB_W     = 10,
    parameter int UNIT_SIZE = 16,
    parameter int DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [DATA_W*UNIT_SIZE-1:0]  din_real,
    input  logic [DATA_W*UNIT_SIZE-1:0]  din_imag,
    output logic                         bf_valid,
    output logic [DATA_W*UNIT_SIZE-1:0]  bf_sr_real,
    output logic [DATA_W*UNIT_SIZE-1:0]  bf_sr_imag,
    output logic [DATA_W*UNIT_SIZE-1:0]  bf_org_real,
    output logic [DATA_W*UNIT_SIZE-1:0]  bf_org_imag,
    input  logic                         sub_valid,
    input  logic [SUB_W*UNIT_SIZE-1:0]   sub_real,
    input  logic [SUB_W*UNIT_SIZE-1:0]   sub_imag,
    output logic                         drain_valid,
    output logic [SUB_W*UNIT_SIZE-1:0]   drain_real,
    output logic [SUB_W*UNIT_SIZE-1:0]   drain_imag
`ifdef SR_FEEDER_OVF_CHK_EN
    ,
    output logic                         ovf
`endif
);

    localparam int DW    = DATA_W * UNIT_SIZE;
    localparam int SW    = SUB_W * UNIT_SIZE;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, PAIR, WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, sub_idx_q, sub_idx_d, drn_idx_q, drn_idx_d;
    logic [SW-1:0]    mem_re [DEPTH];
    logic [SW-1:0]    mem_im [DEPTH];
    logic             bf_valid_q, drain_valid_q;
    logic [DW-1:0]    bf_sr_re_q, bf_sr_im_q, bf_org_re_q, bf_org_im_q;
    logic [SW-1:0]    drain_re_q, drain_im_q;
    logic             accept, fill_wr, pair_rd, sub_wr;

    function automatic logic [SW-1:0] sext_bus(input logic [DW-1:0] x);
        logic [SW-1:0] r;
        r = '0;
        for (int j = 0; j < UNIT_SIZE; j++)
            r[j*SUB_W +: SUB_W] = {{(SUB_W-DATA_W){x[j*DATA_W+DATA_W-1]}}, x[j*DATA_W +: DATA_W]};
        return r;
    endfunction

    function automatic logic [DW-1:0] trunc_bus(input logic [SW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < UNIT_SIZE; j++)
            r[j*DATA_W +: DATA_W] = x[j*SUB_W +: DATA_W];
        return r;
    endfunction

    assign accept  = din_valid && din_ready;
    assign fill_wr = accept && (state_q == FILL);
    assign pair_rd = accept && (state_q == PAIR);
    assign sub_wr  = sub_valid && ((state_q == PAIR) || (state_q == WAIT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            sub_idx_q <= '0;
            drn_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_idx_q <= sub_idx_d;
            drn_idx_q <= drn_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_idx_d = sub_idx_q;
        drn_idx_d = drn_idx_q;
        case (state_q)
            FILL, PAIR: begin
                if (accept) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = (state_q == FILL) ? PAIR : WAIT;
                end
            end
            DRAIN: begin
                drn_idx_d = (drn_idx_q == LAST) ? '0 : drn_idx_q + 1'b1;
                if (drn_idx_q == LAST) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        // The final write-back wins even if it lands while still pairing.
        if (sub_wr) begin
            sub_idx_d = (sub_idx_q == LAST) ? '0 : sub_idx_q + 1'b1;
            if (sub_idx_q == LAST) state_d = DRAIN;
        end
    end

    always_comb begin
        din_ready = (state_q == FILL) || (state_q == PAIR);
    end

    always_ff @(posedge clk) begin
        if (fill_wr) begin
            mem_re[cnt_q] <= sext_bus(din_real);
            mem_im[cnt_q] <= sext_bus(din_imag);
        end else if (sub_wr) begin
            mem_re[sub_idx_q] <= sub_real;
            mem_im[sub_idx_q] <= sub_imag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bf_valid_q    <= 1'b0;
            bf_sr_re_q    <= '0;
            bf_sr_im_q    <= '0;
            bf_org_re_q   <= '0;
            bf_org_im_q   <= '0;
            drain_valid_q <= 1'b0;
            drain_re_q    <= '0;
            drain_im_q    <= '0;
        end else begin
            bf_valid_q    <= pair_rd;
            drain_valid_q <= (state_q == DRAIN);
            if (pair_rd) begin
                bf_sr_re_q  <= trunc_bus(mem_re[cnt_q]);
                bf_sr_im_q  <= trunc_bus(mem_im[cnt_q]);
                bf_org_re_q <= din_real;
                bf_org_im_q <= din_imag;
            end
            if (state_q == DRAIN) begin
                drain_re_q <= mem_re[drn_idx_q];
                drain_im_q <= mem_im[drn_idx_q];
            end
        end
    end

`ifdef SR_FEEDER_OVF_CHK_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_q | (din_valid & ~din_ready);
    end
    assign ovf = ovf_q;
`endif

    assign bf_valid    = bf_valid_q;
    assign bf_sr_real  = bf_sr_re_q;
    assign bf_sr_imag  = bf_sr_im_q;
    assign bf_org_real = bf_org_re_q;
    assign bf_org_imag = bf_org_im_q;
    assign drain_valid = drain_valid_q;
    assign drain_real  = drain_re_q;
    assign drain_imag  = drain_im_q;

endmodule

// File: tb/tb_sr_feeder00.sv
// Scoreboard bench for sr_feeder00 with a one-cycle-lag butterfly model in the loop.
module tb_sr_feeder00;
    localparam int DATA_W = 9, SUB_W = 10, UNIT_SIZE = 16, DEPTH = 16;
    localparam int DW = DATA_W * UNIT_SIZE;
    localparam int SW = SUB_W * UNIT_SIZE;

    logic clk, rstn, din_valid, din_ready, bf_valid, sub_valid, drain_valid;
    logic [DW-1:0] din_real, din_imag, bf_sr_real, bf_sr_imag, bf_org_real, bf_org_imag;
    logic [SW-1:0] sub_real, sub_imag, drain_real, drain_imag;
`ifdef SR_FEEDER_OVF_CHK_EN
    logic ovf;
`endif

    sr_feeder00 #(.DATA_W(DATA_W), .SUB_W(SUB_W), .UNIT_SIZE(UNIT_SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .din_valid(din_valid), .din_ready(din_ready), .din_real(din_real), .din_imag(din_imag),
        .bf_valid(bf_valid), .bf_sr_real(bf_sr_real), .bf_sr_imag(bf_sr_imag),
        .bf_org_real(bf_org_real), .bf_org_imag(bf_org_imag),
        .sub_valid(sub_valid), .sub_real(sub_real), .sub_imag(sub_imag),
        .drain_valid(drain_valid), .drain_real(drain_real), .drain_imag(drain_imag)
`ifdef SR_FEEDER_OVF_CHK_EN
        , .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] sr_re, sr_im, org_re, org_im;
        int            c;
    } bf_exp_t;

    bf_exp_t       bf_q[$];
    logic [SW-1:0] dr_re_q[$];
    logic [SW-1:0] dr_im_q[$];
    logic [DW-1:0] fill_re[DEPTH];
    logic [DW-1:0] fill_im[DEPTH];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // kind: 0/1 first-half re/im, 2/3 second-half re/im
    function automatic logic [DW-1:0] mk(input int f, input int b, input int kind);
        logic [DW-1:0] r;
        logic [31:0]   t;
        r = '0;
        for (int j = 0; j < UNIT_SIZE; j++) begin
            case (kind)
                0:       t = b + j * (3 + f);
                1:       t = -b - j;
                2:       t = 100 + b + j;
                default: t = 50 - b + 2 * j;
            endcase
            r[j*DATA_W +: DATA_W] = t[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] bsub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [SW-1:0]          r;
        logic signed [SUB_W-1:0] x, y;
        r = '0;
        for (int j = 0; j < UNIT_SIZE; j++) begin
            x = {{(SUB_W-DATA_W){a[j*DATA_W+DATA_W-1]}}, a[j*DATA_W +: DATA_W]};
            y = {{(SUB_W-DATA_W){b[j*DATA_W+DATA_W-1]}}, b[j*DATA_W +: DATA_W]};
            r[j*SUB_W +: SUB_W] = x - y;
        end
        return r;
    endfunction

    // Butterfly model and output monitor.
    logic          pend;
    logic [SW-1:0] pend_re, pend_im;
    initial begin
        pend = 1'b0; pend_re = '0; pend_im = '0;
        sub_valid = 1'b0; sub_real = '0; sub_imag = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bf_q.delete(); dr_re_q.delete(); dr_im_q.delete();
                pend = 1'b0; sub_valid = 1'b0;
                continue;
            end
            sub_valid = pend;
            sub_real  = pend_re;
            sub_imag  = pend_im;
            if (pend) begin
                dr_re_q.push_back(pend_re);
                dr_im_q.push_back(pend_im);
            end
            pend = 1'b0;
            if (bf_valid) begin
                if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
                else begin
                    bf_exp_t e;
                    e = bf_q.pop_front();
                    chk("bf_sr_real", bf_sr_real, e.sr_re);
                    chk("bf_sr_imag", bf_sr_imag, e.sr_im);
                    chk("bf_org_real", bf_org_real, e.org_re);
                    chk("bf_org_imag", bf_org_imag, e.org_im);
                    chk("bf_latency", cyc, e.c);
                    pend    = 1'b1;
                    pend_re = bsub(e.sr_re, e.org_re);
                    pend_im = bsub(e.sr_im, e.org_im);
                end
            end
            if (drain_valid) begin
                if (dr_re_q.size() == 0) chk("drain_unexpected", 1, 0);
                else begin
                    chk("drain_real", drain_real, dr_re_q.pop_front());
                    chk("drain_imag", drain_imag, dr_im_q.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input int f, input int b, input int gap);
        bf_exp_t e;
        int      t;
        repeat (gap) @(negedge clk);
        din_real  = (b < DEPTH) ? mk(f, b, 0) : mk(f, b - DEPTH, 2);
        din_imag  = (b < DEPTH) ? mk(f, b, 1) : mk(f, b - DEPTH, 3);
        din_valid = 1'b1;
        t = 0;
        while (!din_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!din_ready) begin
            chk("accept_timeout", 0, 1);
            din_valid = 1'b0;
            return;
        end
        if (b < DEPTH) begin
            fill_re[b] = din_real;
            fill_im[b] = din_imag;
        end else begin
            e.sr_re  = fill_re[b-DEPTH];
            e.sr_im  = fill_im[b-DEPTH];
            e.org_re = din_real;
            e.org_im = din_imag;
            e.c      = cyc + 1;
            bf_q.push_back(e);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic run_frame(input int f, input int gap, input bit hold);
        int n;
        for (int b = 0; b < 2 * DEPTH; b++) begin
            send_beat(f, b, gap);
            if (b == DEPTH - 1) chk("ready_after_fill", din_ready, 1);
        end
        if (hold) begin
            din_valid = 1'b1;
            din_real  = {UNIT_SIZE{9'd77}};
            din_imag  = {UNIT_SIZE{9'd77}};
        end
        n = 0;
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        din_valid = 1'b0;
        chk("ready_low_cycles", n, 18);
        repeat (2) @(negedge clk);
        chk("drain_left", dr_re_q.size(), 0);
        chk("bf_left", bf_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bf_valid"}, bf_valid, 0);
        chk({tag, "_bf_data"}, {bf_sr_real, bf_sr_imag, bf_org_real}, 0);
        chk({tag, "_bf_org_imag"}, bf_org_imag, 0);
        chk({tag, "_drain_valid"}, drain_valid, 0);
        chk({tag, "_drain_data"}, {drain_real, drain_imag}, 0);
        chk({tag, "_din_ready"}, din_ready, 1);
`ifdef SR_FEEDER_OVF_CHK_EN
        chk({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    initial begin
        rstn = 1'b0; din_valid = 1'b0; din_real = '0; din_imag = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);

        run_frame(0, 0, 1'b1);
`ifdef SR_FEEDER_OVF_CHK_EN
        chk("ovf_set", ovf, 1);
`endif
        run_frame(1, 2, 1'b0);
`ifdef SR_FEEDER_OVF_CHK_EN
        chk("ovf_sticky", ovf, 1);
`endif

        for (int b = 0; b < DEPTH + 7; b++) send_beat(2, b, 0);
        din_real  = mk(2, 7, 2);
        din_imag  = mk(2, 7, 3);
        din_valid = 1'b1;
        rstn      = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_frame(3, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_feeder00.md
SR_FEEDER00 -- requirements
Module: sr_feeder00

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, the input sample width (signed).
REQ-002 The block SHALL have parameter SUB_W, default 10, the butterfly subtract-result width (signed), with SUB_W > DATA_W.
REQ-003 The block SHALL have parameter UNIT_SIZE, default 16, the lanes per beat.
REQ-004 The block SHALL have parameter DEPTH, default 16, the beats per half-frame.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port din_valid, input, 1 bit: input beat present.
REQ-008 The block SHALL have port din_ready, output, 1 bit: beat is accepted when din_valid && din_ready.
REQ-009 The block SHALL have ports din_real and din_imag, input, DATA_W x UNIT_SIZE: input samples.
REQ-010 The block SHALL have port bf_valid, output, 1 bit: drives the butterfly valid_in.
REQ-011 The block SHALL have ports bf_sr_real/imag and bf_org_real/imag, output, DATA_W x UNIT_SIZE: delayed and current operands.
REQ-012 The block SHALL have port sub_valid, input, 1 bit: the butterfly valid_out.
REQ-013 The block SHALL have ports sub_real and sub_imag, input, SUB_W x UNIT_SIZE: butterfly subtract results.
REQ-014 The block SHALL have port drain_valid, output, 1 bit: drained-entry strobe.
REQ-015 The block SHALL have ports drain_real and drain_imag, output, SUB_W x UNIT_SIZE: drained subtract results.

Function
REQ-016 Storage SHALL be DEPTH entries, each UNIT_SIZE complex lanes of SUB_W bits; stored inputs are sign-extended from DATA_W.
REQ-017 The FSM SHALL have states FILL, PAIR, WAIT and DRAIN, with a beat counter cnt in the range 0..DEPTH-1.
REQ-018 din_ready SHALL be 1 in FILL and PAIR and 0 in WAIT and DRAIN.
REQ-019 In FILL, each accepted beat SHALL write mem[cnt] and increment cnt; on the beat with cnt = DEPTH-1 the FSM goes to PAIR and cnt wraps to 0.
REQ-020 In PAIR, each accepted beat SHALL register, one cycle later, bf_valid=1, bf_sr = mem[cnt] truncated to DATA_W, and bf_org = din; bf_valid=0 on cycles with no accepted beat.
REQ-021 Each cycle in PAIR or WAIT with sub_valid=1 SHALL write sub_real/imag into mem[sub_idx] and increment sub_idx (range 0..DEPTH-1).
REQ-022 A read of mem[k] SHALL always precede the write of mem[k], which occurs 2 cycles later; no bypass is needed.
REQ-023 After the PAIR beat with cnt = DEPTH-1 the FSM SHALL go to WAIT; when the sub write with sub_idx = DEPTH-1 occurs, it SHALL go to DRAIN with sub_idx = 0.
REQ-024 If that final sub write occurs while still in PAIR, the FSM SHALL go to DRAIN directly.
REQ-025 In DRAIN the block SHALL output mem[0..DEPTH-1] in order, one entry per cycle, on registered drain_real/imag with drain_valid=1, then go to FILL with cnt=0.
REQ-026 sub_valid SHALL be ignored in FILL and DRAIN.
REQ-027 din_valid while din_ready=0 SHALL be ignored; the data is not stored.
REQ-028 bf_* and drain_* data SHALL hold their last value when the corresponding valid is 0.

Reset
REQ-029 On rstn=0, at any time including mid-frame, the block SHALL go to FILL with cnt=0, sub_idx=0, drain index 0, and bf_valid, drain_valid and all bf_*/drain_* data at 0.
REQ-030 din_ready SHALL be 1 after reset; memory contents need not be cleared.

Configuration
REQ-031 With SR_FEEDER_OVF_CHK_EN defined, the block SHALL add output ovf (1 bit), a sticky flag set the cycle after din_valid=1 && din_ready=0 and cleared only by reset.
REQ-032 Without SR_FEEDER_OVF_CHK_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then 16 beats with lane0 real = beat index 0..15 -> din_ready stays 1, bf_valid stays 0, FSM in PAIR.
REQ-034 Next 16 beats with lane0 real = 100+k -> bf_valid=1 for 16 cycles with 1-cycle latency; bf_sr lane0 real = k and bf_org lane0 real = 100+k.
REQ-035 Sub results fed back with 1-cycle lag, lane0 sub_real = -100 -> 16 drain cycles, each drain_real lane0 = -100 (SUB_W sign preserved); din_ready=0 throughout WAIT and DRAIN.
REQ-036 din_valid held 1 during DRAIN with SR_FEEDER_OVF_CHK_EN -> ovf=1 and sticky; the next frame starts clean at cnt=0 after DRAIN.
REQ-037 rstn pulsed low at PAIR beat 7 -> all outputs 0 and din_ready=1; the following 32 beats reproduce the REQ-033/REQ-034 results.
REQ-038 din_valid gapped (1 of every 3 cycles) -> bf_valid pulses align with accepted beats only, and the operand pairing is identical to the REQ-034 results.
